reset_sequencer: RTL and testbench

//  Sits directly downstream of the power-on reset generator. Takes its reset, synchronises
//  the release to sysClock, then frees NUM_DOMAINS subsystem resets one by one, spaced

---
 rtl/reset_sequencer.sv | 177 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises the power-on reset release to sysClock, then frees
// NUM_DOMAINS subsystem resets one at a time, STAGE_DELAY cycles apart. A rising edge
// on softResetReq while running re-runs the whole release sequence.
// Optional feature: define RESET_SEQ_WATCHDOG_EN to add the wdtKick input and a
// run-time watchdog that triggers the same soft-reset sequence on timeout.
module reset_sequencer #(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned STAGE_DELAY = 250,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SOFT_PULSE  = 16,
  parameter int unsigned WDT_TIMEOUT = 1024
) (
  input  logic                   sysClock,
  input  logic                   reset,
  input  logic                   softResetReq,
`ifdef RESET_SEQ_WATCHDOG_EN
  input  logic                   wdtKick,
`endif
  output logic                   softResetAck,
  output logic [NUM_DOMAINS-1:0] domainReset,
  output logic                   allReady,
  output logic [1:0]             seqState
);

  localparam int unsigned MAX_AB = (STAGE_DELAY > SOFT_PULSE) ? STAGE_DELAY : SOFT_PULSE;
  localparam int unsigned MAX_CNT = (MAX_AB > WDT_TIMEOUT) ? MAX_AB : WDT_TIMEOUT;
  localparam int unsigned CNT_W = $clog2(MAX_CNT + 1);
  localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int unsigned CHAIN_W = SYNC_STAGES - 1;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    SOFT    = 2'd3
  } stateT;

  stateT state, stateNext;

  // The state register acts as the final synchroniser stage, so the chain holds one
  // flop fewer than SYNC_STAGES and HOLD exits on the edge that would load that stage.
  logic [CHAIN_W-1:0] syncChain;
  logic               rstS;

  logic [CNT_W-1:0]       cnt, cntNext;
  logic [IDX_W-1:0]       idx, idxNext;
  logic [NUM_DOMAINS-1:0] domainResetNext;
  logic                   allReadyNext;
  logic                   ackNext;
  logic                   prevReq;
  logic                   softEdge;
  logic                   relTick;
  logic                   lastDomain;
  logic                   softTick;
`ifdef RESET_SEQ_WATCHDOG_EN
  logic [CNT_W-1:0]       wdtCnt, wdtCntNext;
  logic                   wdtExpire;
`endif

  assign rstS       = syncChain[CHAIN_W-1];
  assign softEdge   = softResetReq & ~prevReq;
  assign relTick    = (cnt == CNT_W'(STAGE_DELAY - 1));
  assign lastDomain = (idx == IDX_W'(NUM_DOMAINS - 1));
  assign softTick   = (cnt == CNT_W'(SOFT_PULSE - 1));
`ifdef RESET_SEQ_WATCHDOG_EN
  assign wdtExpire  = ~wdtKick & (wdtCnt == CNT_W'(WDT_TIMEOUT - 1));
`endif

  // Reset-release synchroniser and soft-request edge history.
  always_ff @(posedge sysClock or posedge reset) begin
    if (reset) begin
      syncChain <= '1;
      prevReq   <= 1'b0;
    end else begin
      syncChain <= syncChain << 1;
      prevReq   <= softResetReq;
    end
  end

  // State register.
  always_ff @(posedge sysClock or posedge reset) begin
    if (reset) state <= HOLD;
    else       state <= stateNext;
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      HOLD:    if (!rstS) stateNext = RELEASE;
      RELEASE: if (relTick && lastDomain) stateNext = RUN;
      RUN: begin
        if (softEdge) stateNext = SOFT;
`ifdef RESET_SEQ_WATCHDOG_EN
        else if (wdtExpire) stateNext = SOFT;
`endif
      end
      SOFT:    if (softTick) stateNext = RELEASE;
      default: stateNext = HOLD;
    endcase
  end

  // Next values for counters and registered outputs.
  always_comb begin
    cntNext         = cnt;
    idxNext         = idx;
    domainResetNext = domainReset;
    allReadyNext    = allReady;
    ackNext         = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
    wdtCntNext      = '0;
`endif
    case (state)
      HOLD: begin
        cntNext = '0;
        idxNext = '0;
      end
      RELEASE: begin
        if (relTick) begin
          domainResetNext[idx] = 1'b0;
          cntNext              = '0;
          idxNext              = IDX_W'(idx + 1'b1);
          if (lastDomain) allReadyNext = 1'b1;
        end else begin
          cntNext = CNT_W'(cnt + 1'b1);
        end
      end
      RUN: begin
        if (stateNext == SOFT) begin
          domainResetNext = '1;
          allReadyNext    = 1'b0;
          cntNext         = '0;
        end
`ifdef RESET_SEQ_WATCHDOG_EN
        else if (wdtKick) wdtCntNext = '0;
        else              wdtCntNext = CNT_W'(wdtCnt + 1'b1);
`endif
      end
      SOFT: begin
        if (softTick) begin
          ackNext = 1'b1;
          cntNext = '0;
          idxNext = '0;
        end else begin
          cntNext = CNT_W'(cnt + 1'b1);
        end
      end
      default: ;
    endcase
  end

  // Counter and output registers.
  always_ff @(posedge sysClock or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      idx          <= '0;
      domainReset  <= '1;
      allReady     <= 1'b0;
      softResetAck <= 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
      wdtCnt       <= '0;
`endif
    end else begin
      cnt          <= cntNext;
      idx          <= idxNext;
      domainReset  <= domainResetNext;
      allReady     <= allReadyNext;
      softResetAck <= ackNext;
`ifdef RESET_SEQ_WATCHDOG_EN
      wdtCnt       <= wdtCntNext;
`endif
    end
  end

  assign seqState = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (4 domains, 4-cycle stages, 3-cycle soft hold).
// Watchdog scenario is compiled only when RESET_SEQ_WATCHDOG_EN is defined.
module tb_reset_sequencer;

  logic       sysClock;
  logic       reset;
  logic       softResetReq;
  logic       softResetAck;
  logic [3:0] domainReset;
  logic       allReady;
  logic [1:0] seqState;
`ifdef RESET_SEQ_WATCHDOG_EN
  logic       wdtKick;
`endif

  int passCount;
  int checkCount;

  reset_sequencer #(
    .NUM_DOMAINS(4),
    .STAGE_DELAY(4),
    .SYNC_STAGES(2),
    .SOFT_PULSE (3),
    .WDT_TIMEOUT(20)
  ) dut (
    .sysClock    (sysClock),
    .reset       (reset),
    .softResetReq(softResetReq),
`ifdef RESET_SEQ_WATCHDOG_EN
    .wdtKick     (wdtKick),
`endif
    .softResetAck(softResetAck),
    .domainReset (domainReset),
    .allReady    (allReady),
    .seqState    (seqState)
  );

  initial sysClock = 1'b0;
  always #5 sysClock = ~sysClock;

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge sysClock);
    #1;
  endtask

  // Expected domain reset pattern c cycles after entering RELEASE.
  function automatic logic [3:0] expDom(int c);
    if (c >= 16)      return 4'b0000;
    else if (c >= 12) return 4'b1000;
    else if (c >= 8)  return 4'b1100;
    else if (c >= 4)  return 4'b1110;
    else              return 4'b1111;
  endfunction

  task automatic test_reset();
    repeat (2) tick();
    #2 reset = 1'b1;
    #1;
    checkCount++;
    if (domainReset !== 4'b1111) $display("FAIL reset_dom: got %b want 1111", domainReset);
    else passCount++;
    checkCount++;
    if (allReady !== 1'b0) $display("FAIL reset_ready: got %b want 0", allReady);
    else passCount++;
    checkCount++;
    if (softResetAck !== 1'b0) $display("FAIL reset_ack: got %b want 0", softResetAck);
    else passCount++;
    checkCount++;
    if (seqState !== 2'd0) $display("FAIL reset_state: got %0d want 0", seqState);
    else passCount++;
    tick();
    reset = 1'b0;
    tick();
    checkCount++;
    if (seqState !== 2'd0) $display("FAIL sync_edge1: got %0d want 0", seqState);
    else passCount++;
    tick();
    checkCount++;
    if (seqState !== 2'd1) $display("FAIL sync_edge2: got %0d want 1", seqState);
    else passCount++;
  endtask

  task automatic test_release_timing();
    for (int c = 1; c <= 16; c++) begin
      tick();
      checkCount++;
      if (domainReset !== expDom(c))
        $display("FAIL rel_dom c=%0d: got %b want %b", c, domainReset, expDom(c));
      else passCount++;
      if (c == 15) begin
        checkCount++;
        if (allReady !== 1'b0 || seqState !== 2'd1)
          $display("FAIL rel_pre_run: got ready=%b state=%0d want ready=0 state=1", allReady, seqState);
        else passCount++;
      end
      if (c == 16) begin
        checkCount++;
        if (allReady !== 1'b1 || seqState !== 2'd2)
          $display("FAIL rel_run: got ready=%b state=%0d want ready=1 state=2", allReady, seqState);
        else passCount++;
      end
    end
    repeat (3) tick();
    checkCount++;
    if (seqState !== 2'd2 || domainReset !== 4'b0000)
      $display("FAIL run_hold: got state=%0d dom=%b want state=2 dom=0000", seqState, domainReset);
    else passCount++;
  endtask

  task automatic test_soft_reset();
    softResetReq = 1'b1;
    tick();
    checkCount++;
    if (domainReset !== 4'b1111 || seqState !== 2'd3 || allReady !== 1'b0)
      $display("FAIL soft_entry: got dom=%b state=%0d ready=%b want 1111/3/0", domainReset, seqState, allReady);
    else passCount++;
    for (int h = 1; h <= 2; h++) begin
      tick();
      checkCount++;
      if (softResetAck !== 1'b0 || seqState !== 2'd3)
        $display("FAIL soft_hold h=%0d: got ack=%b state=%0d want 0/3", h, softResetAck, seqState);
      else passCount++;
    end
    tick();
    checkCount++;
    if (softResetAck !== 1'b1 || seqState !== 2'd1 || domainReset !== 4'b1111)
      $display("FAIL soft_ack: got ack=%b state=%0d dom=%b want 1/1/1111", softResetAck, seqState, domainReset);
    else passCount++;
    for (int c = 1; c <= 16; c++) begin
      tick();
      checkCount++;
      if (domainReset !== expDom(c) || softResetAck !== 1'b0)
        $display("FAIL soft_rel c=%0d: got dom=%b ack=%b want %b ack=0", c, domainReset, softResetAck, expDom(c));
      else passCount++;
    end
    checkCount++;
    if (seqState !== 2'd2 || allReady !== 1'b1)
      $display("FAIL soft_run: got state=%0d ready=%b want 2/1", seqState, allReady);
    else passCount++;
    repeat (4) tick();
    checkCount++;
    if (seqState !== 2'd2)
      $display("FAIL soft_no_retrigger: got state=%0d want 2", seqState);
    else passCount++;
    softResetReq = 1'b0;
    tick();
    softResetReq = 1'b1;
    tick();
    checkCount++;
    if (seqState !== 2'd3 || domainReset !== 4'b1111)
      $display("FAIL soft_new_edge: got state=%0d dom=%b want 3/1111", seqState, domainReset);
    else passCount++;
    softResetReq = 1'b0;
    repeat (3 + 16) tick();
    checkCount++;
    if (seqState !== 2'd2 || domainReset !== 4'b0000)
      $display("FAIL soft_second_run: got state=%0d dom=%b want 2/0000", seqState, domainReset);
    else passCount++;
  endtask

  task automatic test_ignored_edges();
    logic [31:0] cv;
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
    softResetReq = 1'b1;
    tick();
    checkCount++;
    if (seqState !== 2'd0 || softResetAck !== 1'b0)
      $display("FAIL ign_hold: got state=%0d ack=%b want 0/0", seqState, softResetAck);
    else passCount++;
    softResetReq = 1'b0;
    tick();
    for (int c = 1; c <= 16; c++) begin
      cv = 32'(c);
      softResetReq = (c < 14) ? cv[1] : 1'b0;
      tick();
      checkCount++;
      if (domainReset !== expDom(c) || softResetAck !== 1'b0)
        $display("FAIL ign_rel c=%0d: got dom=%b ack=%b want %b ack=0", c, domainReset, softResetAck, expDom(c));
      else passCount++;
    end
    repeat (3) tick();
    checkCount++;
    if (seqState !== 2'd2 || allReady !== 1'b1)
      $display("FAIL ign_run: got state=%0d ready=%b want 2/1", seqState, allReady);
    else passCount++;
  endtask

  task automatic test_mid_reset();
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (2) tick();
    for (int c = 1; c <= 10; c++) tick();
    checkCount++;
    if (domainReset !== 4'b1100)
      $display("FAIL mid_pre: got %b want 1100", domainReset);
    else passCount++;
    #2 reset = 1'b1;
    #1;
    checkCount++;
    if (domainReset !== 4'b1111 || allReady !== 1'b0 || seqState !== 2'd0 || softResetAck !== 1'b0)
      $display("FAIL mid_abort: got dom=%b ready=%b state=%0d ack=%b want 1111/0/0/0",
               domainReset, allReady, seqState, softResetAck);
    else passCount++;
    tick();
    reset = 1'b0;
    tick();
    tick();
    checkCount++;
    if (seqState !== 2'd1)
      $display("FAIL mid_restart: got state=%0d want 1", seqState);
    else passCount++;
    for (int c = 1; c <= 16; c++) begin
      tick();
      checkCount++;
      if (domainReset !== expDom(c))
        $display("FAIL mid_rel c=%0d: got %b want %b", c, domainReset, expDom(c));
      else passCount++;
    end
    checkCount++;
    if (seqState !== 2'd2 || allReady !== 1'b1)
      $display("FAIL mid_run: got state=%0d ready=%b want 2/1", seqState, allReady);
    else passCount++;
  endtask

`ifdef RESET_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (2 + 16) tick();
    wdtKick = 1'b0;
    repeat (19) tick();
    checkCount++;
    if (seqState !== 2'd2)
      $display("FAIL wdt_pre: got state=%0d want 2", seqState);
    else passCount++;
    tick();
    checkCount++;
    if (seqState !== 2'd3 || domainReset !== 4'b1111)
      $display("FAIL wdt_fire: got state=%0d dom=%b want 3/1111", seqState, domainReset);
    else passCount++;
    repeat (3 + 16) tick();
    for (int i = 0; i < 200; i++) begin
      wdtKick = (i % 10 == 9);
      tick();
      checkCount++;
      if (seqState !== 2'd2)
        $display("FAIL wdt_kick i=%0d: got state=%0d want 2", i, seqState);
      else passCount++;
    end
    wdtKick = 1'b0;
  endtask
`endif

  initial begin
    passCount    = 0;
    checkCount   = 0;
    reset        = 1'b0;
    softResetReq = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
    wdtKick      = 1'b0;
`endif
    test_reset();
    test_release_timing();
    test_soft_reset();
    test_ignored_edges();
    test_mid_reset();
`ifdef RESET_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
